// File: rtl/video_bank_ring.sv
// N-bank ring frame store: round-robin fill from a valid/ready pixel stream,
// upscaled readout of the shown bank, bank swaps only at frame_start.
module video_bank_ring #(
    parameter int NUM_BANKS = 3,
    parameter int PIX_BITS  = 1,
    parameter int SCALE     = 4,
    parameter int ACTIVE_W  = 800,
    parameter int ACTIVE_H  = 600,
    parameter int X_ADDRW   = 11,
    parameter int Y_ADDRW   = 10
) (
    input  logic                CLK_40,
    input  logic                reset,
    input  logic                in_valid,
    input  logic [PIX_BITS-1:0] in_data,
    output logic                in_ready,
    input  logic [X_ADDRW-1:0]  VGA_x_pos,
    input  logic [Y_ADDRW-1:0]  VGA_y_pos,
    input  logic                frame_start,
    output logic [PIX_BITS-1:0] pixel_out,
    output logic                bank_full,
    output logic                frame_done,
    output logic                underflow,
    output logic [15:0]         frames_shown
);
    localparam int MEM_W  = ACTIVE_W / SCALE;
    localparam int MEM_H  = ACTIVE_H / SCALE;
    localparam int DEPTH  = MEM_W * MEM_H;
    localparam int SH     = $clog2(SCALE);
    localparam int WXW    = (MEM_W > 1) ? $clog2(MEM_W) : 1;
    localparam int WYW    = (MEM_H > 1) ? $clog2(MEM_H) : 1;
    localparam int BW     = $clog2(NUM_BANKS);
    localparam int RAM_AW = $clog2(NUM_BANKS * DEPTH);

    typedef enum logic [1:0] {
        B_FREE,
        B_FILL,
        B_FULL,
        B_SHOW
    } bank_state_t;

    bank_state_t bank_q [NUM_BANKS];
    bank_state_t bank_d [NUM_BANKS];

    logic [BW-1:0]       wptr_q, wptr_d;
    logic [BW-1:0]       show_q, show_d;
    logic                show_vld_q, show_vld_d;
    logic [WXW-1:0]      wx_q, wx_d;
    logic [WYW-1:0]      wy_q, wy_d;
    logic [15:0]         frames_d;
    logic                frame_done_d, underflow_d;
    logic [PIX_BITS-1:0] pixel_d;

    logic                accept, last_px, swap;
    logic                next_ok;
    logic [BW-1:0]       next_show;
    logic                in_active;
    logic [RAM_AW-1:0]   waddr, raddr;

    logic [PIX_BITS-1:0] mem [NUM_BANKS*DEPTH];

    assign in_ready = (bank_q[wptr_q] == B_FREE) || (bank_q[wptr_q] == B_FILL);
    assign accept   = in_valid && in_ready;
    assign last_px  = (wx_q == WXW'(MEM_W - 1)) && (wy_q == WYW'(MEM_H - 1));

    assign waddr = RAM_AW'(32'(wptr_q) * DEPTH + 32'(wy_q) * MEM_W + 32'(wx_q));
    assign raddr = RAM_AW'(32'(show_q) * DEPTH
                           + 32'(VGA_y_pos >> SH) * MEM_W
                           + 32'(VGA_x_pos >> SH));

    assign in_active = (32'(VGA_x_pos) < ACTIVE_W) && (32'(VGA_y_pos) < ACTIVE_H);

    always_comb begin
        bank_full = 1'b0;
        for (int unsigned i = 0; i < NUM_BANKS; i++) begin
            if (bank_q[i] == B_FULL) bank_full = 1'b1;
        end
    end

    // Swap candidate: successor of the shown bank, or the lowest FULL bank
    // when nothing has been shown since reset (always bank 0 in practice).
    always_comb begin
        next_ok   = 1'b0;
        next_show = '0;
        if (show_vld_q) begin
            next_show = (show_q == BW'(NUM_BANKS - 1)) ? '0 : show_q + BW'(1);
            next_ok   = (bank_q[next_show] == B_FULL);
        end else begin
            for (int unsigned i = 0; i < NUM_BANKS; i++) begin
                if (!next_ok && bank_q[i] == B_FULL) begin
                    next_ok   = 1'b1;
                    next_show = BW'(i);
                end
            end
        end
    end

    assign swap = frame_start && next_ok;

    always_comb begin
        for (int unsigned i = 0; i < NUM_BANKS; i++) bank_d[i] = bank_q[i];
        wptr_d       = wptr_q;
        wx_d         = wx_q;
        wy_d         = wy_q;
        show_d       = show_q;
        show_vld_d   = show_vld_q;
        frames_d     = frames_shown;
        frame_done_d = 1'b0;
        underflow_d  = 1'b0;
        pixel_d      = '0;

        if (accept) begin
            bank_d[wptr_q] = last_px ? B_FULL : B_FILL;
            if (last_px) begin
                wx_d   = '0;
                wy_d   = '0;
                wptr_d = (wptr_q == BW'(NUM_BANKS - 1)) ? '0 : wptr_q + BW'(1);
            end else if (wx_q == WXW'(MEM_W - 1)) begin
                wx_d = '0;
                wy_d = wy_q + WYW'(1);
            end else begin
                wx_d = wx_q + WXW'(1);
            end
        end

        // The write bank is never SHOW or FULL, so these updates never collide.
        if (swap) begin
            if (show_vld_q) bank_d[show_q] = B_FREE;
            bank_d[next_show] = B_SHOW;
            show_d            = next_show;
            show_vld_d        = 1'b1;
            frames_d          = frames_shown + 16'd1;
        end
        frame_done_d = swap && show_vld_q;
        underflow_d  = frame_start && !next_ok;

        if (in_active && show_vld_q) pixel_d = mem[raddr];
    end

    always_ff @(posedge CLK_40) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_BANKS; i++) bank_q[i] <= B_FREE;
            wptr_q       <= '0;
            show_q       <= '0;
            show_vld_q   <= 1'b0;
            wx_q         <= '0;
            wy_q         <= '0;
            frames_shown <= '0;
            frame_done   <= 1'b0;
            underflow    <= 1'b0;
            pixel_out    <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_BANKS; i++) bank_q[i] <= bank_d[i];
            wptr_q       <= wptr_d;
            show_q       <= show_d;
            show_vld_q   <= show_vld_d;
            wx_q         <= wx_d;
            wy_q         <= wy_d;
            frames_shown <= frames_d;
            frame_done   <= frame_done_d;
            underflow    <= underflow_d;
            pixel_out    <= pixel_d;
        end
    end

    always_ff @(posedge CLK_40) begin
        if (accept) mem[waddr] <= in_data;
    end

endmodule

// File: tb/tb_video_bank_ring.sv
// Directed + randomized bench for video_bank_ring against a frame-queue reference model.
module tb_video_bank_ring;
    localparam int NB    = 3;
    localparam int PB    = 2;
    localparam int SC    = 4;
    localparam int AW    = 16;
    localparam int AH    = 8;
    localparam int MW    = AW / SC;
    localparam int MH    = AH / SC;
    localparam int DEPTH = MW * MH;
    localparam int FB    = PB * DEPTH;

    logic          CLK_40 = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic [PB-1:0] in_data = '0;
    logic          in_ready;
    logic [10:0]   VGA_x_pos = '0;
    logic [9:0]    VGA_y_pos = '0;
    logic          frame_start = 1'b0;
    logic [PB-1:0] pixel_out;
    logic          bank_full;
    logic          frame_done;
    logic          underflow;
    logic [15:0]   frames_shown;

    video_bank_ring #(
        .NUM_BANKS(NB),
        .PIX_BITS (PB),
        .SCALE    (SC),
        .ACTIVE_W (AW),
        .ACTIVE_H (AH),
        .X_ADDRW  (11),
        .Y_ADDRW  (10)
    ) dut (
        .CLK_40      (CLK_40),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .VGA_x_pos   (VGA_x_pos),
        .VGA_y_pos   (VGA_y_pos),
        .frame_start (frame_start),
        .pixel_out   (pixel_out),
        .bank_full   (bank_full),
        .frame_done  (frame_done),
        .underflow   (underflow),
        .frames_shown(frames_shown)
    );

    always #5 CLK_40 = ~CLK_40;

    int checks = 0;
    int errors = 0;

    // Reference model: queue of completed frames awaiting display, the frame
    // being assembled, and the frame currently on screen.
    logic [FB-1:0] fullq [$];
    logic [FB-1:0] fill_buf;
    logic [FB-1:0] shown_frame;
    int            fill_cnt;
    bit            shown_vld;
    logic [15:0]   m_frames;
    bit            m_acc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input bit v, input logic [PB-1:0] d, input int x, input int y, input bit fs);
        logic          exp_ready, exp_fd, exp_uf;
        logic [PB-1:0] exp_px;
        in_valid    = v;
        in_data     = d;
        VGA_x_pos   = 11'(x);
        VGA_y_pos   = 10'(y);
        frame_start = fs;
        #1;
        exp_ready = (fullq.size() + int'(shown_vld)) < NB;
        check("in_ready", 32'(in_ready), 32'(exp_ready));
        check("bank_full", 32'(bank_full), 32'(fullq.size() != 0));
        exp_px = '0;
        if (shown_vld && x < AW && y < AH)
            exp_px = shown_frame[((y / SC) * MW + x / SC) * PB +: PB];
        exp_fd = 1'b0;
        exp_uf = 1'b0;
        if (fs) begin
            if (fullq.size() != 0) begin
                exp_fd      = shown_vld;
                shown_frame = fullq.pop_front();
                shown_vld   = 1'b1;
                m_frames    = m_frames + 16'd1;
            end else begin
                exp_uf = 1'b1;
            end
        end
        m_acc = v && exp_ready;
        if (m_acc) begin
            fill_buf[fill_cnt * PB +: PB] = d;
            fill_cnt++;
            if (fill_cnt == DEPTH) begin
                fullq.push_back(fill_buf);
                fill_cnt = 0;
            end
        end
        @(posedge CLK_40);
        #1;
        check("pixel_out", 32'(pixel_out), 32'(exp_px));
        check("frame_done", 32'(frame_done), 32'(exp_fd));
        check("underflow", 32'(underflow), 32'(exp_uf));
        check("frames_shown", 32'(frames_shown), 32'(m_frames));
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        in_valid    = 1'b0;
        in_data     = '0;
        frame_start = 1'b0;
        VGA_x_pos   = '0;
        VGA_y_pos   = '0;
        @(posedge CLK_40);
        #1;
        reset = 1'b0;
        fullq.delete();
        fill_cnt  = 0;
        shown_vld = 1'b0;
        m_frames  = '0;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_bank_full", 32'(bank_full), 32'd0);
        check("rst_pixel_out", 32'(pixel_out), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_underflow", 32'(underflow), 32'd0);
        check("rst_frames_shown", 32'(frames_shown), 32'd0);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++)
            tick(1'b0, '0, $urandom_range(0, AW + 3), $urandom_range(0, AH + 1), 1'b0);
    endtask

    task automatic frame_sync();
        tick(1'b0, '0, 0, 0, 1'b1);
    endtask

    // val < 0 selects random pixel data; completes the frame in progress.
    task automatic fill_frame(input int val);
        int            need;
        int            got;
        logic [PB-1:0] d;
        need = DEPTH - fill_cnt;
        got  = 0;
        for (int k = 0; k < 200 && got < need; k++) begin
            d = (val < 0) ? PB'($urandom) : PB'(val);
            tick(1'b1, d, $urandom_range(0, AW + 3), $urandom_range(0, AH + 1), 1'b0);
            if (m_acc) got++;
        end
        check("fill_timeout", 32'(got), 32'(need));
    endtask

    initial begin
        do_reset();

        // Frame of 1s streamed with in_valid held high, then shown
        fill_frame(1);
        idle(1);
        frame_sync();
        idle(20);
        tick(1'b0, '0, AW, 0, 1'b0);
        tick(1'b0, '0, 0, AH, 1'b0);
        tick(1'b0, '0, AW - 1, AH - 1, 1'b0);

        // Distinct frames 2 and 3 fill remaining banks; writer stalls
        fill_frame(2);
        fill_frame(3);
        for (int k = 0; k < 5; k++) tick(1'b1, PB'($urandom), 1, 1, 1'b0);
        frame_sync();
        idle(12);
        frame_sync();
        idle(12);
        // No FULL bank left: repeat frame 3
        frame_sync();
        idle(12);

        // Random traffic with occasional frame_start
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 15) == 0)
                tick($urandom_range(0, 3) != 0, PB'($urandom), 0, 0, 1'b1);
            else
                tick($urandom_range(0, 3) != 0, PB'($urandom),
                     $urandom_range(0, AW + 3), $urandom_range(0, AH + 1), 1'b0);
        end

        // Drain FULL banks, then land the last pixel on a frame_start cycle
        for (int k = 0; k < NB + 1 && fullq.size() != 0; k++) frame_sync();
        for (int k = 0; k < 100 && fill_cnt != DEPTH - 1; k++)
            tick(1'b1, PB'($urandom), $urandom_range(0, AW - 1), $urandom_range(0, AH - 1), 1'b0);
        check("pre_last_px", 32'(fill_cnt), 32'(DEPTH - 1));
        tick(1'b1, 2'd3, 0, 0, 1'b1);
        idle(3);
        frame_sync();
        idle(12);

        // Reset while a frame is partially filled
        fill_frame(-1);
        for (int k = 0; k < 3; k++) tick(1'b1, PB'($urandom), 2, 2, 1'b0);
        do_reset();
        idle(4);
        frame_sync();
        fill_frame(-1);
        frame_sync();
        idle(16);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
